mem_prog_loader: RTL and testbench
==================================

MEM_PROG_LOADER -- requirements
Module: mem_prog_loader

Interface
REQ-001 SHALL have parameter DataWidth, default 32, memory word width in bits; must be a multiple of 8 and at most 64.
REQ-002 SHALL have parameter AddrWidth, default 12, word address width.
REQ-003 SHALL have parameter NumBanks, default 2, number of target memories (0=ICCM, 1=DCCM).
REQ-004 SHALL have parameter TimeoutCycles, default 65536, idle-byte timeout in clk_i cycles.
REQ-005 SHALL have port clk_i  input  1  the single clock.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port prog_i  input  1  programming-mode request, level.
REQ-008 SHALL have port rx_dv_i  input  1  one-cycle strobe marking a valid received byte.
REQ-009 SHALL have port rx_byte_i  input  8  received byte.
REQ-010 SHALL have port we_o  output  NumBanks  one-hot write strobe per bank.
REQ-011 SHALL have port addr_o  output  AddrWidth  word write address.
REQ-012 SHALL have port wdata_o  output  DataWidth  write data.
REQ-013 SHALL have port prog_rst_no  output  1  active-low hold-reset for the core.
REQ-014 SHALL have port busy_o, done_o  output  1 each  load in progress / last load succeeded.
REQ-015 SHALL have port err_o  output  1  last load failed; err_code_o  output  3  failure cause.

Function
REQ-016 SHALL accept the frame: bank byte, length L (16-bit, LSB first), L words of DataWidth/8 bytes each (LSB first), then one checksum byte.
REQ-017 SHALL use FSM states IDLE, HDR_BANK, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-018 SHALL move from IDLE, DONE or ERR to HDR_BANK on a prog_i rising edge, clearing done_o, err_o, err_code_o, the word counter and the checksum.
REQ-019 SHALL drive prog_rst_no low in the cycle after entering HDR_BANK and hold it low in every state except DONE.
REQ-020 SHALL release prog_rst_no (drive it high) in the cycle after entering DONE.
REQ-021 SHALL compute the checksum as the 8-bit modulo-256 sum of every frame byte before the checksum byte.
REQ-022 SHALL register a full data word and pulse we_o[bank] for exactly one cycle, one cycle after the word's last byte strobe, with addr_o equal to the word index (first word at 0).
REQ-023 SHALL go directly from LEN1 to CSUM when L=0, issuing no writes.
REQ-024 SHALL enter ERR with code 1 if the bank byte is >= NumBanks, and with code 2 if L > 2**AddrWidth; no writes occur in either case.
REQ-025 SHALL enter ERR with code 3 on checksum mismatch and enter DONE on a match.
REQ-026 SHALL enter ERR with code 4 if TimeoutCycles cycles pass with no rx_dv_i while in any receiving state.
REQ-027 SHALL enter ERR with code 5 if prog_i falls while in any receiving state; a write pulse already registered still completes.
REQ-028 SHALL ignore rx_dv_i while in IDLE, DONE or ERR.
REQ-029 SHALL drive busy_o high exactly in states HDR_BANK through CSUM.
REQ-030 SHALL drive we_o to all-zero in every cycle except the write-pulse cycle of REQ-022.

Reset
REQ-031 SHALL, while rst_ni is low, force the state to IDLE and drive we_o=0, addr_o=0, wdata_o=0, prog_rst_no=1, busy_o=0, done_o=0, err_o=0, err_code_o=0, and clear all counters.
REQ-032 SHALL treat prog_i as already high after reset if it is sampled high, with no rising edge detected until prog_i falls and rises again.

Structure
REQ-033 SHALL place the state enum, the err_code enum and the frame-constant localparams in a shared package prog_loader_pkg.
REQ-034 SHALL have one sub-module, prog_word_assembler, which does byte-to-word shifting and the last-byte flag.
REQ-035 SHALL implement the timeout counter with ceil(log2(TimeoutCycles+1)) bits, cleared on every rx_dv_i.

Verification
REQ-036 SHALL cover: bank 0, L=2, words 0x11223344 and 0xAABBCCDD, correct checksum -> we_o=01 at addr 0 then addr 1 with those data; done_o=1; prog_rst_no rises one cycle after DONE.
REQ-037 SHALL cover: bank 1, L=1, checksum off by one -> one write on we_o=10; err_o=1, err_code_o=3; prog_rst_no stays 0.
REQ-038 SHALL cover: bank byte 0x02 with NumBanks=2 -> ERR with code 1; zero writes; later bytes ignored.
REQ-039 SHALL cover: L=0 with checksum 0x00 -> DONE with zero writes.
REQ-040 SHALL cover: TimeoutCycles=100, stall mid-word -> ERR with code 4 at cycle 100; then a new prog_i rising edge followed by a valid frame -> DONE.
REQ-041 SHALL cover: rst_ni asserted during DATA -> all outputs at reset values immediately (asynchronously), prog_rst_no=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and constants for the memory program loader.
//   state_e     : loader FSM states
//   err_code_e  : failure causes reported on err_code_o
//   ByteWidth, LenWidth, CsumWidth : fixed widths of the serial frame fields
//   is_receiving() : true in the states that consume frame bytes
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int unsigned ByteWidth = 8;
  localparam int unsigned LenWidth  = 16;
  localparam int unsigned CsumWidth = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_BANK = 3'd1,
    LEN0     = 3'd2,
    LEN1     = 3'd3,
    DATA     = 3'd4,
    CSUM     = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BANK    = 3'd1,
    ERR_LEN     = 3'd2,
    ERR_CSUM    = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_ABORT   = 3'd5
  } err_code_e;

  // States in which the loader is in the middle of a frame.
  function automatic logic is_receiving(input state_e s);
    return (s == HDR_BANK) || (s == LEN0) || (s == LEN1) ||
           (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/mem_prog_loader_if.sv
// -----------------------------------------------------------------------------
// mem_prog_loader_if
// Byte stream link: a one-cycle valid strobe plus the byte it qualifies.
//   dv   : byte valid strobe
//   data : received byte
// Modports: master drives the stream, slave consumes it.
// -----------------------------------------------------------------------------
interface mem_prog_loader_if;
  import prog_loader_pkg::*;

  logic                 dv;
  logic [ByteWidth-1:0] data;

  modport master (output dv, output data);
  modport slave  (input dv, input data);

endinterface

// File: rtl/prog_word_assembler.sv
// -----------------------------------------------------------------------------
// prog_word_assembler
// Collects bytes (least significant first) into DataWidth-bit words.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : drops any partially assembled word
//   rx         : incoming byte stream (slave side)
//   word       : assembled word including the byte currently on rx
//   last       : high when the byte on rx completes a word
// DataWidth must be a multiple of 8 and at most 64.
// -----------------------------------------------------------------------------
module prog_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  mem_prog_loader_if.slave     rx,
  output logic [DataWidth-1:0] word,
  output logic                 last
);

  localparam int unsigned BytesPerWord = DataWidth / ByteWidth;
  localparam int unsigned CntWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(BytesPerWord - 1);

  logic [DataWidth-1:0] shift_q;
  logic [CntWidth-1:0]  cnt_q;

  // New byte enters at the top and everything moves down one byte, so after
  // BytesPerWord strobes the first byte sits in the least significant lane.
  // Shifting the concatenation avoids an empty slice when DataWidth is 8.
  assign word = DataWidth'({rx.data, shift_q} >> ByteWidth);
  assign last = rx.dv && (cnt_q == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (rx.dv) begin
      shift_q <= word;
      cnt_q   <= last ? '0 : cnt_q + CntWidth'(1);
    end
  end

endmodule

// File: rtl/mem_prog_loader.sv
// -----------------------------------------------------------------------------
// mem_prog_loader
// Receives a program image over a byte stream and writes it into one of
// NumBanks memories while holding the core in reset.
// Frame: bank byte, 16-bit length L (LSB first), L words of DataWidth/8 bytes
// (LSB first), one checksum byte (mod-256 sum of all preceding frame bytes).
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   prog_i          : programming request level; a rising edge starts a load
//   rx_dv_i         : one-cycle valid strobe for rx_byte_i
//   rx_byte_i       : received byte
//   we_o            : one-hot per-bank write strobe
//   addr_o, wdata_o : word address and data for the write
//   prog_rst_no     : active-low core reset, released after a good load
//   busy_o          : load in progress
//   done_o, err_o   : last load succeeded / failed
//   err_code_o      : failure cause (see err_code_e)
// -----------------------------------------------------------------------------
module mem_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned NumBanks      = 2,
  parameter int unsigned TimeoutCycles = 65536
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 prog_i,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  output logic [NumBanks-1:0]  we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 prog_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           err_code_o
);

  localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);
  // Largest word count that fits the address space; 33 bits so that
  // 2**AddrWidth stays representable for any sensible AddrWidth.
  localparam logic [32:0] MaxWords = 33'(1) << AddrWidth;

  state_e    state_q, state_d;
  err_code_e err_code_q, err_code_d;

  logic                 prog_q;
  logic                 prog_rise;
  logic                 prog_fall;
  logic                 receiving;
  logic                 start;
  logic                 do_write;

  logic [7:0]           bank_q;
  logic [7:0]           len_lo_q;
  logic [LenWidth-1:0]  len_q;
  logic [LenWidth-1:0]  len_full;
  logic [LenWidth-1:0]  word_cnt_q;
  logic [CsumWidth-1:0] csum_q;
  logic [TmoWidth-1:0]  tmo_q;

  logic [NumBanks-1:0]  we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 prog_rst_n_q;

  logic [DataWidth-1:0] asm_word;
  logic                 asm_last;

  mem_prog_loader_if rx_bus ();

  assign prog_rise = prog_i && !prog_q;
  assign prog_fall = !prog_i && prog_q;
  assign receiving = is_receiving(state_q);
  assign len_full  = {rx_byte_i, len_lo_q};

  // Only payload bytes reach the assembler; outside DATA it is held empty so
  // every word starts aligned at the first payload byte.
  assign rx_bus.dv   = rx_dv_i && (state_q == DATA);
  assign rx_bus.data = rx_byte_i;

  prog_word_assembler #(
    .DataWidth (DataWidth)
  ) u_assembler (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (state_q != DATA),
    .rx    (rx_bus),
    .word  (asm_word),
    .last  (asm_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Abort on prog_i falling beats everything else, including a word that
  // completes in the same cycle. The timeout fires on the TimeoutCycles-th
  // consecutive cycle without a strobe.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    start      = 1'b0;
    do_write   = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (prog_rise) begin
          state_d    = HDR_BANK;
          err_code_d = ERR_NONE;
          start      = 1'b1;
        end
      end
      HDR_BANK: begin
        if (rx_dv_i) begin
          if (32'(rx_byte_i) >= NumBanks) begin
            state_d    = ERR;
            err_code_d = ERR_BANK;
          end else begin
            state_d = LEN0;
          end
        end
      end
      LEN0: begin
        if (rx_dv_i) begin
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (rx_dv_i) begin
          if (33'(len_full) > MaxWords) begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end else if (len_full == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (asm_last) begin
          do_write = 1'b1;
          if (word_cnt_q == len_q - LenWidth'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_dv_i) begin
          if (rx_byte_i == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (receiving) begin
      if (prog_fall) begin
        state_d    = ERR;
        err_code_d = ERR_ABORT;
        do_write   = 1'b0;
      end else if (!rx_dv_i && (tmo_q == TmoLast)) begin
        state_d    = ERR;
        err_code_d = ERR_TIMEOUT;
      end
    end
  end

  // prog_q resets high so a request already asserted during reset is not
  // mistaken for a new rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_q     <= 1'b1;
      bank_q     <= '0;
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
    end else begin
      prog_q <= prog_i;
      if (start) begin
        word_cnt_q <= '0;
        csum_q     <= '0;
        tmo_q      <= '0;
      end else if (receiving) begin
        if (rx_dv_i) begin
          csum_q <= csum_q + rx_byte_i;
          tmo_q  <= '0;
        end else begin
          tmo_q <= tmo_q + TmoWidth'(1);
        end
        if (rx_dv_i && (state_q == HDR_BANK)) begin
          bank_q <= rx_byte_i;
        end
        if (rx_dv_i && (state_q == LEN0)) begin
          len_lo_q <= rx_byte_i;
        end
        if (rx_dv_i && (state_q == LEN1)) begin
          len_q <= len_full;
        end
        if (do_write) begin
          word_cnt_q <= word_cnt_q + LenWidth'(1);
        end
      end
    end
  end

  // The write port is registered, so the strobe lands one cycle after the
  // last byte of the word and lasts exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= '0;
      if (do_write) begin
        we_q    <= NumBanks'(1) << bank_q;
        addr_q  <= AddrWidth'(word_cnt_q);
        wdata_q <= asm_word;
      end
    end
  end

  // Core reset follows the state one cycle late: released a cycle after
  // DONE is reached, asserted a cycle after any load starts, and left high
  // in IDLE so the core runs normally out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_rst_n_q <= 1'b1;
    end else if (state_q == DONE) begin
      prog_rst_n_q <= 1'b1;
    end else if (state_q != IDLE) begin
      prog_rst_n_q <= 1'b0;
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_rst_no = prog_rst_n_q;
  assign busy_o      = receiving;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == ERR);
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_mem_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_prog_loader
// Self-checking bench for mem_prog_loader (DataWidth 32, AddrWidth 12,
// NumBanks 2, TimeoutCycles 100). Frames come from a vector table with
// hand-written expected outcomes; reset, core-reset timing, timeout, abort
// and asynchronous reset are exercised by dedicated sequences.
// -----------------------------------------------------------------------------
module tb_mem_prog_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NB = 2;
  localparam int unsigned TC = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prog;
  logic [NB-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          prog_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    err_code;

  mem_prog_loader_if rx_bus ();

  always #5 clk = ~clk;

  mem_prog_loader #(
    .DataWidth     (DW),
    .AddrWidth     (AW),
    .NumBanks      (NB),
    .TimeoutCycles (TC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .prog_i      (prog),
    .rx_dv_i     (rx_bus.dv),
    .rx_byte_i   (rx_bus.data),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .prog_rst_no (prog_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code)
  );

  typedef struct packed {
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  bank;
    logic [15:0] len;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [7:0]  delta;
    logic        exp_done;
    logic [2:0]  exp_code;
    int          exp_writes;
  } vec_t;

  wr_t  wr_log[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  // Every write strobe seen mid-cycle is logged; a strobe wider than one
  // cycle shows up as an extra entry.
  always @(negedge clk) begin
    if (we != '0) wr_log.push_back({we, addr, wdata});
  end

  task automatic checkValue(input string name, input logic [63:0] actual,
                            input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordOf(input vec_t v, input int i);
    case (i)
      0:       return v.w0;
      1:       return v.w1;
      default: return v.w2;
    endcase
  endfunction

  function automatic logic [7:0] frameSum(input vec_t v);
    logic [7:0]  s;
    logic [31:0] w;
    s = v.bank + v.len[7:0] + v.len[15:8];
    for (int i = 0; i < v.nwords; i++) begin
      w = wordOf(v, i);
      s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    return s;
  endfunction

  function automatic vec_t mkVec(input logic [7:0] bank, input logic [15:0] len,
                                 input int nwords, input logic [31:0] w0,
                                 input logic [31:0] w1, input logic [31:0] w2,
                                 input logic [7:0] delta, input logic exp_done,
                                 input logic [2:0] exp_code, input int exp_writes);
    vec_t v;
    v.bank = bank; v.len = len; v.nwords = nwords;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.delta = delta;
    v.exp_done = exp_done; v.exp_code = exp_code; v.exp_writes = exp_writes;
    return v;
  endfunction

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_bus.dv   = 1'b1;
    rx_bus.data = b;
    @(negedge clk);
    rx_bus.dv   = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sendByte(w[8*b +: 8]);
  endtask

  task automatic progRise();
    @(negedge clk);
    prog = 1'b0;
    @(negedge clk);
    prog = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_log.delete();
    progRise();
    sendByte(v.bank);
    sendByte(v.len[7:0]);
    sendByte(v.len[15:8]);
    for (int i = 0; i < v.nwords; i++) sendWord(wordOf(v, i));
    sendByte(frameSum(v) + v.delta);
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [NB-1:0] exp_we;
    exp_we = NB'(1) << v.bank;
    checkValue($sformatf("v%0d done", idx), 64'(done), 64'(v.exp_done));
    checkValue($sformatf("v%0d err", idx), 64'(err), 64'(v.exp_code != 3'd0));
    checkValue($sformatf("v%0d err_code", idx), 64'(err_code), 64'(v.exp_code));
    checkValue($sformatf("v%0d busy", idx), 64'(busy), 64'd0);
    checkValue($sformatf("v%0d prog_rst_n", idx), 64'(prog_rst_n), 64'(v.exp_done));
    checkValue($sformatf("v%0d write count", idx), 64'(wr_log.size()), 64'(v.exp_writes));
    for (int i = 0; i < v.exp_writes; i++) begin
      if (i < wr_log.size()) begin
        checkValue($sformatf("v%0d wr%0d we", idx, i), 64'(wr_log[i].we), 64'(exp_we));
        checkValue($sformatf("v%0d wr%0d addr", idx, i), 64'(wr_log[i].addr), 64'(i));
        checkValue($sformatf("v%0d wr%0d data", idx, i), 64'(wr_log[i].data), 64'(wordOf(v, i)));
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, " we"}, 64'(we), 64'd0);
    checkValue({tag, " addr"}, 64'(addr), 64'd0);
    checkValue({tag, " wdata"}, 64'(wdata), 64'd0);
    checkValue({tag, " prog_rst_n"}, 64'(prog_rst_n), 64'd1);
    checkValue({tag, " busy"}, 64'(busy), 64'd0);
    checkValue({tag, " done"}, 64'(done), 64'd0);
    checkValue({tag, " err"}, 64'(err), 64'd0);
    checkValue({tag, " err_code"}, 64'(err_code), 64'd0);
  endtask

  initial begin
    //          bank   len       nw w0            w1            w2            delta  done code writes
    vecs[0] = mkVec(8'h00, 16'h0002, 2, 32'h11223344, 32'hAABBCCDD, 32'h0,        8'h00, 1'b1, 3'd0, 2);
    vecs[1] = mkVec(8'h01, 16'h0001, 1, 32'h5A5A0FF0, 32'h0,        32'h0,        8'h01, 1'b0, 3'd3, 1);
    vecs[2] = mkVec(8'h02, 16'h0001, 1, 32'hDEADBEEF, 32'h0,        32'h0,        8'h00, 1'b0, 3'd1, 0);
    vecs[3] = mkVec(8'h00, 16'h0000, 0, 32'h0,        32'h0,        32'h0,        8'h00, 1'b1, 3'd0, 0);
    vecs[4] = mkVec(8'h01, 16'h0003, 3, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 8'h00, 1'b1, 3'd0, 3);
    vecs[5] = mkVec(8'h00, 16'h1001, 0, 32'h0,        32'h0,        32'h0,        8'h00, 1'b0, 3'd2, 0);
    vecs[6] = mkVec(8'h01, 16'h0000, 0, 32'h0,        32'h0,        32'h0,        8'h00, 1'b1, 3'd0, 0);
    vecs[7] = mkVec(8'h00, 16'h0001, 1, 32'h01020304, 32'h0,        32'h0,        8'hFF, 1'b0, 3'd3, 1);

    rst_n       = 1'b0;
    prog        = 1'b1;
    rx_bus.dv   = 1'b0;
    rx_bus.data = 8'h00;

    // Reset values, with prog already high through reset.
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkValue("prog high from reset no start", 64'(busy), 64'd0);
    checkValue("prog high from reset prog_rst_n", 64'(prog_rst_n), 64'd1);

    // Core reset timing around an empty frame.
    progRise();
    @(negedge clk);
    checkValue("hdr entry busy", 64'(busy), 64'd1);
    checkValue("hdr entry prog_rst_n", 64'(prog_rst_n), 64'd1);
    @(negedge clk);
    checkValue("hdr+1 prog_rst_n", 64'(prog_rst_n), 64'd0);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    checkValue("done entry done", 64'(done), 64'd1);
    checkValue("done entry prog_rst_n", 64'(prog_rst_n), 64'd0);
    @(negedge clk);
    checkValue("done+1 prog_rst_n", 64'(prog_rst_n), 64'd1);
    wr_log.delete();
    sendByte(8'h55);
    checkValue("byte in DONE ignored", 64'(done), 64'd1);
    checkValue("byte in DONE no write", 64'(wr_log.size()), 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Stall inside a word: the error appears on the 100th idle cycle.
    wr_log.delete();
    progRise();
    sendByte(8'h00);
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h44);
    sendByte(8'h33);
    repeat (99) @(negedge clk);
    checkValue("timeout 99 idle err", 64'(err), 64'd0);
    checkValue("timeout 99 idle busy", 64'(busy), 64'd1);
    @(negedge clk);
    checkValue("timeout 100 idle err", 64'(err), 64'd1);
    checkValue("timeout err_code", 64'(err_code), 64'd4);
    checkValue("timeout prog_rst_n", 64'(prog_rst_n), 64'd0);
    checkValue("timeout writes", 64'(wr_log.size()), 64'd0);
    begin
      vec_t rec;
      rec = mkVec(8'h00, 16'h0001, 1, 32'hCAFEF00D, 32'h0, 32'h0, 8'h00, 1'b1, 3'd0, 1);
      applyStimulus(rec);
      checkOutput(rec, 100);
    end

    // L = 2**AddrWidth is accepted; prog_i drops right after a word write.
    wr_log.delete();
    progRise();
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h10);
    checkValue("max len busy", 64'(busy), 64'd1);
    checkValue("max len err", 64'(err), 64'd0);
    sendWord(32'h0BADF00D);
    checkValue("abort pre we", 64'(we), 64'd1);
    checkValue("abort pre wdata", 64'(wdata), 64'h0BADF00D);
    prog = 1'b0;
    @(negedge clk);
    checkValue("abort err", 64'(err), 64'd1);
    checkValue("abort err_code", 64'(err_code), 64'd5);
    checkValue("abort we cleared", 64'(we), 64'd0);
    checkValue("abort writes", 64'(wr_log.size()), 64'd1);

    // Asynchronous reset while a write strobe is showing.
    progRise();
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h00);
    sendWord(32'h12345678);
    checkValue("pre reset we", 64'(we), 64'd2);
    checkValue("pre reset wdata", 64'(wdata), 64'h12345678);
    checkValue("pre reset prog_rst_n", 64'(prog_rst_n), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("post reset no restart", 64'(busy), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
